pipefft_dly_ctrl: RTL
=====================

# pipefft_dly_ctrl

Control and data-path wrapper for the 8-deep × 66-bit pipeFFT delay-line RAM, which has registered read address and registered read data. It sits directly upstream of that RAM and also takes its read data, turning it into a fixed sample delay line for the SDF stage. The block generates the write and read addresses and the write enable, and compensates for the RAM's 2-cycle read latency. It presents a delayed sample stream with a valid strobe to the downstream butterfly commutator.

## Interface
Parameters:
- WIDTH, 66, sample word width (matches RAM data width)
- AW, 3, RAM address width; DEPTH = 2**AW = 8 slots
- DLY, DEPTH-1 (=7), sample delay; fixed, not run-time programmable

Ports:
- clk  in  1  single clock; drives RAM wClk and rClk
- nGrst  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush; empties the delay line
- inValid  in  1  input sample strobe; each assertion advances the line by one sample
- inD  in  WIDTH  input sample
- outValid  out  1  delayed-sample strobe
- outD  out  WIDTH  delayed sample (registered)
- fillDone  out  1  high once DLY samples are held
- wEn  out  1  RAM write enable (combinational = inValid & ~clr)
- wAddr  out  AW  RAM write address (= wptr)
- wD  out  WIDTH  RAM write data (= inD)
- rAddr  out  AW  RAM read address (combinational = wptr+1 mod DEPTH)
- rD  in  WIDTH  RAM read data; valid 2 cycles after rAddr is sampled

## Operation
State:
- wptr: AW-bit write pointer.
- fill: saturating counter, 0..DLY.
- issue pipe: 2-bit shift register rp[1:0].
- Output registers: outD, outValid.

Advance cycle (inValid=1, clr=0):
- The RAM writes inD at wptr at the clock edge. In parallel, the RAM samples rAddr = wptr+1, which is the oldest slot.
- wptr ← wptr+1, wrapping 7→0.
- fill ← min(fill+1, DLY).
- rp[0] ← (fill == DLY). A read is only tagged valid if the slot holds a real sample.

Non-advance cycle: wptr and fill hold, and rp[0] ← 0.

Issue pipe and output:
- The issue pipe free-runs every cycle: rp[1] ← rp[0].
- outValid ← rp[1].
- When rp[1] = 1: outD ← rD. Otherwise outD holds.

Addressing rules:
- rAddr is never equal to wAddr, so there is no read-during-write collision.
- rAddr changes only when wptr advances. Stalls therefore do not corrupt data already in flight in the RAM pipeline.

Delay:
- With fill == DLY, the sample read from slot wptr+1 is the input from 7 advances earlier.
- Output sample n equals input sample n−7. The first 7 inputs after reset or clr produce no output.

fillDone = (fill == DLY).

clr (synchronous; has priority over inValid):
- wptr ← 0, fill ← 0, rp ← 00, outValid ← 0.
- outD holds.
- wEn is forced low.

Reset values (nGrst=0, asynchronous):
- wptr = 0, fill = 0, rp = 00.
- outValid = 0, outD = 0, fillDone = 0.

## Timing
Latency:
- inValid in cycle t → the matching outValid is high in cycle t+3.
- The RAM samples the address at the end of t. rD is valid in t+2. outD is registered at the end of t+2.

Throughput:
- One sample per cycle with inValid continuously high.
- outValid is then continuous, starting 3 cycles after the 8th input.

Gaps and stalls:
- outValid pulses mirror the inValid gaps exactly, delayed by 3 cycles.
- No back-pressure exists; the downstream stage must accept every outValid.

Wrap-around: wptr 7→0 and rAddr 7→0 wrap seamlessly, with no bubble.

Simultaneous events:
- clr together with inValid: clr wins and the sample is dropped.
- Reads already in flight at clr are discarded, because rp is cleared.

Reset mid-stream:
- All state clears immediately.
- RAM contents are not cleared. Stale data is never marked valid because fill restarts at 0.

## Test plan
- Reset then continuous inValid, inD = 1,2,3,…,20 → outValid first high 3 cycles after inD=8 is accepted. outD sequence is 1,2,…,13; fillDone rises in the cycle after the 7th input.
- Gapped input: inValid pattern 1,0,0,1,… with values 1..16 → outD sequence 1..9. Each outValid occurs exactly 3 cycles after its triggering inValid; no duplicates and no skips.
- Wrap check: 24 continuous samples → wAddr/rAddr cycle 0..7 three times, rAddr == wAddr+1 mod 8 every cycle, and outputs stay correct across the 7→0 boundaries.
- clr asserted with inValid in the middle of the 12th sample → outValid stays low for the rest of the cycles whose reads were in flight. The next 7 inputs give no output; the 8th post-clr input yields the 1st post-clr sample.
- Async nGrst pulse mid-stream, between clock edges → outValid, outD and fillDone go to 0 immediately. Refill behaves as after power-up, with no stale RAM data emitted.
- Full-width data: alternating 0x3_FFFF_FFFF_FFFF_FFFF and 0x0 patterns → all 66 bits are delayed intact, with no lane swap across the six 11-bit RAM columns.

Source files
------------

// File: rtl/pipefft_dly_ctrl.sv
`default_nettype none
// pipefft_dly_ctrl: drives the 8x66 pipeFFT RAM (registered address and data) as a
// fixed DLY-sample delay line and re-aligns its read data with a 2-stage issue pipe.
module pipefft_dly_ctrl #(
  parameter int WIDTH = 66,
  parameter int AW    = 3,
  parameter int DLY   = (2**AW) - 1
) (
  input  logic             clk,
  input  logic             nGrst,
  input  logic             clr,
  input  logic             inValid,
  input  logic [WIDTH-1:0] inD,
  output logic             outValid,
  output logic [WIDTH-1:0] outD,
  output logic             fillDone,
  output logic             wEn,
  output logic [AW-1:0]    wAddr,
  output logic [WIDTH-1:0] wD,
  output logic [AW-1:0]    rAddr,
  input  logic [WIDTH-1:0] rD
);

  // The read slot is always wptr+1, so the delay only equals DLY when DLY = DEPTH-1.
  localparam logic [AW-1:0] DLY_V = AW'(DLY);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [1:0]       rp_q, rp_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outD_q, outD_d;
  logic             full;

  assign full = (fill_q == DLY_V);

  always_comb begin
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    rp_d       = {rp_q[0], 1'b0};
    outValid_d = rp_q[1];
    outD_d     = rp_q[1] ? rD : outD_q;
    if (clr) begin
      wptr_d     = '0;
      fill_d     = '0;
      rp_d       = 2'b00;
      outValid_d = 1'b0;
      outD_d     = outD_q;
    end else if (inValid) begin
      wptr_d  = wptr_q + 1'b1;
      fill_d  = full ? fill_q : fill_q + 1'b1;
      rp_d[0] = full;
    end
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      wptr_q     <= '0;
      fill_q     <= '0;
      rp_q       <= 2'b00;
      outValid_q <= 1'b0;
      outD_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      rp_q       <= rp_d;
      outValid_q <= outValid_d;
      outD_q     <= outD_d;
    end
  end

  assign wEn      = inValid & ~clr;
  assign wAddr    = wptr_q;
  assign wD       = inD;
  assign rAddr    = wptr_q + 1'b1;
  assign outValid = outValid_q;
  assign outD     = outD_q;
  assign fillDone = full;

endmodule
`default_nettype wire
